// File: rtl/calc_key_sequencer_if.sv
// Key-event handshake and Sel holder-control bus between the keypad front end,
// the calc_key_sequencer (master) and the holders/environment (slave).
interface calc_key_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              key_valid;
   logic              key_ready;
   logic [1:0]        key_type;
   logic [DATA_W-1:0] key_data;
   logic [2:0]        Sel;
   logic [DATA_W-1:0] Operand;
   logic [1:0]        Op;
   logic              result_valid;
   logic              err;

   modport master (
      input  key_valid, key_type, key_data,
      output key_ready, Sel, Operand, Op, result_valid, err
   );

   modport slave (
      output key_valid, key_type, key_data,
      input  key_ready, Sel, Operand, Op, result_valid, err
   );
endinterface

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: turns accepted key events into one-cycle Sel holder commands.
// Optional macro SEQ_ERR_STICKY_EN: err latches on an illegal key until a clear key or reset.
module calc_key_sequencer #(
   parameter int RESULT_LAT = 2,
   parameter int DATA_W     = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   calc_key_sequencer_if.master bus
);
   localparam logic [2:0] SEL_HOLD   = 3'b000;
   localparam logic [2:0] SEL_LOAD_A = 3'b001;
   localparam logic [2:0] SEL_LOAD_B = 3'b010;
   localparam logic [2:0] SEL_LOAD_OP = 3'b011;
   localparam logic [2:0] SEL_CLEAR  = 3'b100;
   localparam logic [2:0] SEL_COMP   = 3'b101;
   localparam logic [2:0] SEL_A_RES  = 3'b110;

   localparam logic [1:0] KEY_NUM   = 2'b00;
   localparam logic [1:0] KEY_OPER  = 2'b01;
   localparam logic [1:0] KEY_EQ    = 2'b10;
   localparam logic [1:0] KEY_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      INIT, WAIT_A, HAVE_A, WAIT_B, HAVE_B, COMPUTE, DONE, RELOAD_OP
   } state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [2:0]        sel_reg;
   logic [DATA_W-1:0] operand_reg;
   logic [1:0]        op_reg;
   logic              result_valid_reg;
   logic              err_reg;
   logic              ready;
   logic              accept;

   always_comb begin
      ready = 1'b0;
      case (state)
         WAIT_A, HAVE_A, WAIT_B, HAVE_B, DONE: ready = reset_n;
         default:                             ready = 1'b0;
      endcase
   end

   assign accept = ready & bus.key_valid;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state            <= INIT;
         cnt              <= '0;
         sel_reg          <= SEL_HOLD;
         operand_reg      <= '0;
         op_reg           <= '0;
         result_valid_reg <= 1'b0;
         err_reg          <= 1'b0;
      end else begin
         sel_reg <= SEL_HOLD;
`ifndef SEQ_ERR_STICKY_EN
         err_reg <= 1'b0;
`endif
         case (state)
            // Holders have no reset, so clear them once on the way out of reset.
            INIT: begin
               sel_reg <= SEL_CLEAR;
               state   <= WAIT_A;
            end
            COMPUTE: begin
               if (cnt == 4'd0) begin
                  result_valid_reg <= 1'b1;
                  state            <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RELOAD_OP: begin
               sel_reg <= SEL_LOAD_OP;
               state   <= WAIT_B;
            end
            default: begin
               if (accept) begin
                  if (bus.key_type == KEY_CLEAR) begin
                     sel_reg          <= SEL_CLEAR;
                     operand_reg      <= '0;
                     result_valid_reg <= 1'b0;
`ifdef SEQ_ERR_STICKY_EN
                     err_reg          <= 1'b0;
`endif
                     state            <= WAIT_A;
                  end else begin
                     case (state)
                        WAIT_A: begin
                           if (bus.key_type == KEY_NUM) begin
                              sel_reg     <= SEL_LOAD_A;
                              operand_reg <= bus.key_data;
                              state       <= HAVE_A;
                           end else begin
                              err_reg <= 1'b1;
                           end
                        end
                        HAVE_A: begin
                           case (bus.key_type)
                              KEY_NUM: begin
                                 sel_reg     <= SEL_LOAD_A;
                                 operand_reg <= bus.key_data;
                              end
                              KEY_OPER: begin
                                 sel_reg <= SEL_LOAD_OP;
                                 op_reg  <= bus.key_data[1:0];
                                 state   <= WAIT_B;
                              end
                              default: err_reg <= 1'b1;
                           endcase
                        end
                        WAIT_B: begin
                           case (bus.key_type)
                              KEY_NUM: begin
                                 sel_reg     <= SEL_LOAD_B;
                                 operand_reg <= bus.key_data;
                                 state       <= HAVE_B;
                              end
                              KEY_OPER: begin
                                 sel_reg <= SEL_LOAD_OP;
                                 op_reg  <= bus.key_data[1:0];
                              end
                              default: err_reg <= 1'b1;
                           endcase
                        end
                        HAVE_B: begin
                           // A second operator here is simply dropped.
                           case (bus.key_type)
                              KEY_NUM: begin
                                 sel_reg     <= SEL_LOAD_B;
                                 operand_reg <= bus.key_data;
                              end
                              KEY_EQ: begin
                                 sel_reg <= SEL_COMP;
                                 cnt     <= 4'(RESULT_LAT - 1);
                                 state   <= COMPUTE;
                              end
                              default: ;
                           endcase
                        end
                        DONE: begin
                           case (bus.key_type)
                              KEY_NUM: begin
                                 sel_reg          <= SEL_LOAD_A;
                                 operand_reg      <= bus.key_data;
                                 result_valid_reg <= 1'b0;
                                 state            <= HAVE_A;
                              end
                              // Chain on the result: copy it into A, then load the operator.
                              KEY_OPER: begin
                                 sel_reg          <= SEL_A_RES;
                                 op_reg           <= bus.key_data[1:0];
                                 result_valid_reg <= 1'b0;
                                 state            <= RELOAD_OP;
                              end
                              default: ;
                           endcase
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign bus.key_ready    = ready;
   assign bus.Sel          = sel_reg;
   assign bus.Operand      = operand_reg;
   assign bus.Op           = op_reg;
   assign bus.result_valid = result_valid_reg;
   assign bus.err          = err_reg;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: the driver queues expected Sel/result/err
// events with their cycle stamps, and a negedge monitor pops and compares them.
module tb_calc_key_sequencer;
   localparam int LAT = 4;
   localparam logic [1:0] K_NUM = 2'b00, K_OPER = 2'b01, K_EQ = 2'b10, K_CLR = 2'b11;
   localparam int EV_SEL = 0, EV_RV = 1, EV_ERR = 2;
`ifdef SEQ_ERR_STICKY_EN
   localparam int STICKY = 1;
`else
   localparam int STICKY = 0;
`endif

   typedef struct {
      int         kind;
      logic [2:0] sel;
      logic [7:0] operand;
      logic [1:0] op;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;
   int   tests   = 0;
   int   fails   = 0;
   logic rv_prev = 1'b0;
   logic err_prev = 1'b0;

   calc_key_sequencer_if #(.DATA_W(8)) bus ();

   calc_key_sequencer #(.RESULT_LAT(LAT), .DATA_W(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [2:0] sel, input logic [7:0] operand,
                       input logic [1:0] op, input int c);
      exp_t e;
      e.kind = kind; e.sel = sel; e.operand = operand; e.op = op; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind);
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: kind=%0d Sel=%0d Operand=%0h Op=%0d at cycle %0d, expected none",
                  kind, bus.Sel, bus.Operand, bus.Op, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc ||
             (kind == EV_SEL && (e.sel != bus.Sel || e.operand != bus.Operand || e.op != bus.Op))) begin
            fails++;
            $display("FAIL event: got kind=%0d Sel=%0d Operand=%0h Op=%0d cycle=%0d, expected kind=%0d Sel=%0d Operand=%0h Op=%0d cycle=%0d",
                     kind, bus.Sel, bus.Operand, bus.Op, cyc, e.kind, e.sel, e.operand, e.op, e.cyc);
         end else begin
            $display("[TB] cycle %0d event kind=%0d Sel=%0d Operand=%0h Op=%0d ok",
                     cyc, kind, bus.Sel, bus.Operand, bus.Op);
         end
      end
   endtask

   always @(negedge clock) begin
      if (bus.Sel != 3'b000) observe(EV_SEL);
      if (bus.result_valid && !rv_prev) observe(EV_RV);
      if (bus.err && !err_prev) observe(EV_ERR);
      rv_prev  <= bus.result_valid;
      err_prev <= bus.err;
   end

   // Returns the posedge index at which the key was accepted.
   task automatic send_key(input logic [1:0] t, input logic [7:0] d, output int acc);
      int n;
      n = 0;
      @(negedge clock);
      bus.key_valid = 1'b1;
      bus.key_type  = t;
      bus.key_data  = d;
      while (!bus.key_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!bus.key_ready) begin
         tests++;
         fails++;
         $display("FAIL key_accept_timeout: key_ready=0 after %0d cycles, expected 1", n);
         acc = -1;
      end else begin
         acc = cyc + 1;
      end
      @(posedge clock);
      #1 bus.key_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard_drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel"}, bus.Sel, 0);
      check({tag, "_operand"}, bus.Operand, 0);
      check({tag, "_op"}, bus.Op, 0);
      check({tag, "_result_valid"}, bus.result_valid, 0);
      check({tag, "_err"}, bus.err, 0);
      check({tag, "_key_ready"}, bus.key_ready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a2, e, c;
      bus.key_valid = 1'b0;
      bus.key_type  = 2'b00;
      bus.key_data  = 8'h00;

      // Reset and the INIT clear pulse.
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      push(EV_SEL, 3'b100, 8'h00, 2'd0, cyc + 1);
      check("ready_in_init", bus.key_ready, 0);
      @(negedge clock);
      check("ready_after_init", bus.key_ready, 1);
      @(negedge clock);
      check("sel_back_to_hold", bus.Sel, 0);
      wait_drain();

      // 0x12 op2 0x05 = : full entry sequence and result latency.
      send_key(K_NUM, 8'h12, a);  push(EV_SEL, 3'b001, 8'h12, 2'd0, a);
      send_key(K_OPER, 8'h02, a); push(EV_SEL, 3'b011, 8'h12, 2'd2, a);
      send_key(K_NUM, 8'h05, a);  push(EV_SEL, 3'b010, 8'h05, 2'd2, a);
      send_key(K_EQ, 8'h00, a);   push(EV_SEL, 3'b101, 8'h05, 2'd2, a);
      push(EV_RV, 3'b000, 8'h00, 2'd0, a + LAT);
      @(negedge clock);
      check("ready_in_compute", bus.key_ready, 0);
      wait_drain();
      check("result_valid_done", bus.result_valid, 1);

      // Operator in DONE chains on the result.
      send_key(K_OPER, 8'h01, a);
      push(EV_SEL, 3'b110, 8'h05, 2'd1, a);
      push(EV_SEL, 3'b011, 8'h05, 2'd1, a + 1);
      @(negedge clock);
      check("ready_during_reload", bus.key_ready, 0);
      check("result_valid_cleared_chain", bus.result_valid, 0);
      send_key(K_NUM, 8'h07, a2);
      check("reload_accept_cycle", a2, a + 2);
      push(EV_SEL, 3'b010, 8'h07, 2'd1, a2);
      wait_drain();

      // Clear, then illegal keys in WAIT_A.
      send_key(K_CLR, 8'h00, a);  push(EV_SEL, 3'b100, 8'h00, 2'd1, a);
      send_key(K_EQ, 8'h00, a);   push(EV_ERR, 3'b000, 8'h00, 2'd0, a);
      @(negedge clock);
      check("err_set", bus.err, 1);
      @(negedge clock);
      check("err_after_one_cycle", bus.err, STICKY);
      send_key(K_OPER, 8'h03, a);
      if (STICKY == 0) push(EV_ERR, 3'b000, 8'h00, 2'd0, a);
      send_key(K_NUM, 8'h33, a);  push(EV_SEL, 3'b001, 8'h33, 2'd1, a);
      @(negedge clock);
      check("err_before_clear", bus.err, STICKY);
      send_key(K_CLR, 8'h00, a);  push(EV_SEL, 3'b100, 8'h00, 2'd1, a);
      @(negedge clock);
      check("err_after_clear", bus.err, 0);
      wait_drain();

      // Clear held during COMPUTE is accepted only once DONE is reached.
      send_key(K_NUM, 8'h0A, a);  push(EV_SEL, 3'b001, 8'h0A, 2'd1, a);
      send_key(K_OPER, 8'h03, a); push(EV_SEL, 3'b011, 8'h0A, 2'd3, a);
      send_key(K_NUM, 8'h04, a);  push(EV_SEL, 3'b010, 8'h04, 2'd3, a);
      send_key(K_EQ, 8'h00, e);   push(EV_SEL, 3'b101, 8'h04, 2'd3, e);
      push(EV_RV, 3'b000, 8'h00, 2'd0, e + LAT);
      send_key(K_CLR, 8'h00, c);
      check("clear_held_in_compute", c, e + LAT + 1);
      push(EV_SEL, 3'b100, 8'h00, 2'd3, c);
      @(negedge clock);
      check("result_valid_cleared_by_clear", bus.result_valid, 0);
      check("ready_after_clear", bus.key_ready, 1);
      wait_drain();

      // Reset mid-COMPUTE aborts and repeats the INIT clear.
      send_key(K_NUM, 8'h01, a);  push(EV_SEL, 3'b001, 8'h01, 2'd3, a);
      send_key(K_OPER, 8'h00, a); push(EV_SEL, 3'b011, 8'h01, 2'd0, a);
      send_key(K_NUM, 8'h02, a);  push(EV_SEL, 3'b010, 8'h02, 2'd0, a);
      send_key(K_EQ, 8'h00, e);   push(EV_SEL, 3'b101, 8'h02, 2'd0, e);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      check_all_zero("abort");
      reset_n = 1'b1;
      push(EV_SEL, 3'b100, 8'h00, 2'd0, cyc + 1);
      repeat (LAT + 4) @(negedge clock);
      wait_drain();
      check("no_result_after_abort", bus.result_valid, 0);

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
